// File: rtl/dac_update_scheduler_pkg.sv
// Shared definitions for the DAC update scheduler.
// Holds the FSM state type, the DAC command prefix, default DAC I2C addresses,
// the channel count and a helper that builds the command byte for a channel.
package dac_ctrl_pkg;

  localparam int unsigned NUM_CH = 16;
  localparam int unsigned CH_W   = 4;

  // Command byte prefix; the low three bits carry the channel within one DAC.
  localparam logic [4:0] CMD_BASE = 5'b00001;

  localparam logic [6:0] DAC1_ADDR_DEF = 7'h2A;  // channels 0-7
  localparam logic [6:0] DAC2_ADDR_DEF = 7'h2B;  // channels 8-15

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StLdac
  } state_e;

  function automatic logic [7:0] make_cmd(input logic [CH_W-1:0] ch);
    return {CMD_BASE, ch[2:0]};
  endfunction

endpackage

// File: rtl/dac_update_scheduler_if.sv
// Request/completion bus between the DAC update scheduler and the byte-level
// I2C master.
//   req   : transaction request (scheduler -> master)
//   addr  : 7-bit DAC address
//   cmd   : command byte
//   data  : 16-bit left-justified DAC word
//   ready : master can accept a request
//   done  : single-cycle pulse at transaction end
//   nack  : qualifies done; 1 = NACK received
interface dac_update_scheduler_if;
  logic        req;
  logic [6:0]  addr;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        ready;
  logic        done;
  logic        nack;

  modport master (
    output req,
    output addr,
    output cmd,
    output data,
    input  ready,
    input  done,
    input  nack
  );

  modport slave (
    input  req,
    input  addr,
    input  cmd,
    input  data,
    output ready,
    output done,
    output nack
  );
endinterface

// File: rtl/dac_update_scheduler_rr_picker.sv
// Combinational round-robin priority encoder.
// Searches the dirty vector starting one past last_ch_i (wrapping) and grants
// the first set bit.
//   dirty_i       : per-channel pending-update flags
//   last_ch_i     : most recently serviced channel
//   grant_valid_o : at least one channel is dirty
//   grant_ch_o    : selected channel
module rr_picker
  import dac_ctrl_pkg::*;
(
  input  logic [NUM_CH-1:0] dirty_i,
  input  logic [CH_W-1:0]   last_ch_i,
  output logic              grant_valid_o,
  output logic [CH_W-1:0]   grant_ch_o
);

  logic [CH_W-1:0] idx;

  always_comb begin
    grant_valid_o = 1'b0;
    grant_ch_o    = '0;
    idx           = '0;
    // Offsets 1..NUM_CH; the last offset wraps back onto last_ch itself.
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      idx = last_ch_i + CH_W'(i);
      if (!grant_valid_o && dirty_i[idx]) begin
        grant_valid_o = 1'b1;
        grant_ch_o    = idx;
      end
    end
  end

endmodule

// File: rtl/dac_update_scheduler.sv
// DAC update scheduler for two 8-channel I2C DACs (16 channels).
// Keeps a shadow code and dirty flag per channel, flushes dirty channels
// round-robin as I2C write requests with bounded NACK retry, then issues one
// LDAC pulse per (merged) commit so all outputs update together.
//   clk, reset   : clock, asynchronous active-high reset
//   wr_en_i      : host shadow write strobe; wr_ch_i / wr_data_i select/code
//   commit_i     : request an LDAC pulse after pending updates are flushed
//   err_clr_i    : clear error_o and err_ch_o
//   i2c          : request/completion bus to the I2C master
//   ldac_n_o     : active-low LDAC to both DACs
//   busy_o       : FSM not idle
//   error_o      : sticky retry-exhausted flag; err_ch_o = offending channel
module dac_update_scheduler
  import dac_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned MAX_RETRY  = 3,
  parameter int unsigned LDAC_PULSE = 4,
  parameter logic [6:0]  DAC1_ADDR  = DAC1_ADDR_DEF,
  parameter logic [6:0]  DAC2_ADDR  = DAC2_ADDR_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en_i,
  input  logic [CH_W-1:0]       wr_ch_i,
  input  logic [DATA_W-1:0]     wr_data_i,
  input  logic                  commit_i,
  input  logic                  err_clr_i,
  dac_update_scheduler_if.master i2c,
  output logic                  ldac_n_o,
  output logic                  busy_o,
  output logic                  error_o,
  output logic [CH_W-1:0]       err_ch_o
);

  localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int unsigned LdacW  = (LDAC_PULSE > 1) ? $clog2(LDAC_PULSE) : 1;
  localparam int unsigned Pad    = 16 - DATA_W;

  state_e              st_q, st_d;
  logic [DATA_W-1:0]   shadow_q [NUM_CH];
  logic [NUM_CH-1:0]   dirty_q, dirty_d;
  logic [CH_W-1:0]     last_ch_q, last_ch_d;
  logic [CH_W-1:0]     cur_ch_q, cur_ch_d;
  logic [RetryW-1:0]   retry_q, retry_d;
  logic [LdacW-1:0]    cnt_q, cnt_d;
  logic                commit_pend_q, commit_pend_d;
  logic                rewr_q, rewr_d;
  logic                req_q, req_d;
  logic [6:0]          addr_q, addr_d;
  logic [7:0]          cmd_q, cmd_d;
  logic [15:0]         data_q, data_d;
  logic                ldac_n_q, ldac_n_d;
  logic                busy_q, busy_d;
  logic                error_q, error_d;
  logic [CH_W-1:0]     err_ch_q, err_ch_d;

  logic                grant_valid;
  logic [CH_W-1:0]     grant_ch;
  logic                clr_dirty;
  logic                wr_hit;

  rr_picker u_picker (
    .dirty_i      (dirty_q),
    .last_ch_i    (last_ch_q),
    .grant_valid_o(grant_valid),
    .grant_ch_o   (grant_ch)
  );

  assign wr_hit = wr_en_i && (wr_ch_i == cur_ch_q);

  always_comb begin
    st_d          = st_q;
    cur_ch_d      = cur_ch_q;
    last_ch_d     = last_ch_q;
    retry_d       = retry_q;
    cnt_d         = cnt_q;
    rewr_d        = rewr_q;
    req_d         = req_q;
    addr_d        = addr_q;
    cmd_d         = cmd_q;
    data_d        = data_q;
    ldac_n_d      = ldac_n_q;
    error_d       = error_q;
    err_ch_d      = err_ch_q;
    commit_pend_d = commit_pend_q | commit_i;
    clr_dirty     = 1'b0;

    if (err_clr_i) begin
      error_d  = 1'b0;
      err_ch_d = '0;
    end

    unique case (st_q)
      StIdle: begin
        if (grant_valid) begin
          cur_ch_d = grant_ch;
          retry_d  = '0;
          // A write landing on the same edge as the sample makes it stale.
          rewr_d   = wr_en_i && (wr_ch_i == grant_ch);
          req_d    = 1'b1;
          addr_d   = grant_ch[3] ? DAC2_ADDR : DAC1_ADDR;
          cmd_d    = make_cmd(grant_ch);
          data_d   = 16'(shadow_q[grant_ch]) << Pad;
          st_d     = StIssue;
        end else if (commit_pend_q) begin
          // The pulse consumes the pending commit; later commits re-arm it.
          commit_pend_d = 1'b0;
          ldac_n_d      = 1'b0;
          cnt_d         = '0;
          st_d          = StLdac;
        end
      end
      StIssue: begin
        if (wr_hit) rewr_d = 1'b1;
        if (i2c.ready) begin
          req_d = 1'b0;
          st_d  = StWait;
        end
      end
      StWait: begin
        if (wr_hit) rewr_d = 1'b1;
        if (i2c.done) begin
          if (!i2c.nack) begin
            clr_dirty = !(rewr_q || wr_hit);
            last_ch_d = cur_ch_q;
            st_d      = StIdle;
          end else if (retry_q < RetryW'(MAX_RETRY)) begin
            retry_d = retry_q + RetryW'(1);
            req_d   = 1'b1;
            st_d    = StIssue;
          end else begin
            error_d   = 1'b1;
            err_ch_d  = cur_ch_q;
            clr_dirty = 1'b1;
            last_ch_d = cur_ch_q;
            st_d      = StIdle;
          end
        end
      end
      StLdac: begin
        if (cnt_q == LdacW'(LDAC_PULSE - 1)) begin
          ldac_n_d = 1'b1;
          st_d     = StIdle;
        end else begin
          cnt_d = cnt_q + LdacW'(1);
        end
      end
      default: st_d = StIdle;
    endcase

    busy_d = (st_d != StIdle);
  end

  // Host writes always win over a completion clear in the same cycle.
  always_comb begin
    dirty_d = dirty_q;
    if (clr_dirty) dirty_d[cur_ch_q] = 1'b0;
    if (wr_en_i)   dirty_d[wr_ch_i]  = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) shadow_q[i] <= '0;
    end else if (wr_en_i) begin
      shadow_q[wr_ch_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q          <= StIdle;
      dirty_q       <= '0;
      last_ch_q     <= CH_W'(NUM_CH - 1);
      cur_ch_q      <= '0;
      retry_q       <= '0;
      cnt_q         <= '0;
      commit_pend_q <= 1'b0;
      rewr_q        <= 1'b0;
      req_q         <= 1'b0;
      addr_q        <= '0;
      cmd_q         <= '0;
      data_q        <= '0;
      ldac_n_q      <= 1'b1;
      busy_q        <= 1'b0;
      error_q       <= 1'b0;
      err_ch_q      <= '0;
    end else begin
      st_q          <= st_d;
      dirty_q       <= dirty_d;
      last_ch_q     <= last_ch_d;
      cur_ch_q      <= cur_ch_d;
      retry_q       <= retry_d;
      cnt_q         <= cnt_d;
      commit_pend_q <= commit_pend_d;
      rewr_q        <= rewr_d;
      req_q         <= req_d;
      addr_q        <= addr_d;
      cmd_q         <= cmd_d;
      data_q        <= data_d;
      ldac_n_q      <= ldac_n_d;
      busy_q        <= busy_d;
      error_q       <= error_d;
      err_ch_q      <= err_ch_d;
    end
  end

  assign i2c.req  = req_q;
  assign i2c.addr = addr_q;
  assign i2c.cmd  = cmd_q;
  assign i2c.data = data_q;
  assign ldac_n_o = ldac_n_q;
  assign busy_o   = busy_q;
  assign error_o  = error_q;
  assign err_ch_o = err_ch_q;

endmodule

// File: tb/tb_dac_update_scheduler.sv
// Directed self-checking bench for dac_update_scheduler.
module tb_dac_update_scheduler;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [3:0]  wr_ch;
  logic [11:0] wr_data;
  logic        commit;
  logic        err_clr;
  logic        ldac_n;
  logic        busy;
  logic        error;
  logic [3:0]  err_ch;

  int checks = 0;
  int fails  = 0;

  dac_update_scheduler_if i2c_bus ();

  dac_update_scheduler dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en_i  (wr_en),
    .wr_ch_i  (wr_ch),
    .wr_data_i(wr_data),
    .commit_i (commit),
    .err_clr_i(err_clr),
    .i2c      (i2c_bus),
    .ldac_n_o (ldac_n),
    .busy_o   (busy),
    .error_o  (error),
    .err_ch_o (err_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write(input logic [3:0] ch, input logic [11:0] code);
    wr_en   = 1'b1;
    wr_ch   = ch;
    wr_data = code;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".req"},    32'(i2c_bus.req),  32'd0);
    check({tag, ".addr"},   32'(i2c_bus.addr), 32'd0);
    check({tag, ".cmd"},    32'(i2c_bus.cmd),  32'd0);
    check({tag, ".data"},   32'(i2c_bus.data), 32'd0);
    check({tag, ".ldac_n"}, 32'(ldac_n),       32'd1);
    check({tag, ".busy"},   32'(busy),         32'd0);
    check({tag, ".error"},  32'(error),        32'd0);
    check({tag, ".err_ch"}, 32'(err_ch),       32'd0);
  endtask

  // Waits for a request, checks its fields, completes it with ACK or NACK.
  // Optionally pulses commit and/or rewrites the channel while in WAIT.
  task automatic expect_txn(input string tag, input logic [3:0] ch, input logic [11:0] code,
                            input bit nack, input bit cmt, input bit rw,
                            input logic [11:0] rw_code);
    int n;
    logic [6:0]  e_addr;
    logic [7:0]  e_cmd;
    logic [15:0] e_data;
    e_addr = ch[3] ? 7'h2B : 7'h2A;
    e_cmd  = {5'b00001, ch[2:0]};
    e_data = {code, 4'b0000};
    n = 0;
    while (!i2c_bus.req && n < 60) begin
      tick();
      n++;
    end
    check({tag, ".req_seen"}, 32'(i2c_bus.req), 32'd1);
    check({tag, ".addr"}, 32'(i2c_bus.addr), 32'(e_addr));
    check({tag, ".cmd"},  32'(i2c_bus.cmd),  32'(e_cmd));
    check({tag, ".data"}, 32'(i2c_bus.data), 32'(e_data));
    tick();
    check({tag, ".req_drop"}, 32'(i2c_bus.req), 32'd0);
    if (cmt) pulse_commit();
    if (rw) write(ch, rw_code);
    tick();
    check({tag, ".ldac_idle"}, 32'(ldac_n), 32'd1);
    check({tag, ".busy"}, 32'(busy), 32'd1);
    i2c_bus.done = 1'b1;
    i2c_bus.nack = nack;
    tick();
    i2c_bus.done = 1'b0;
    i2c_bus.nack = 1'b0;
  endtask

  task automatic expect_ldac(input string tag);
    int n;
    int low;
    n = 0;
    while (ldac_n && n < 60) begin
      tick();
      n++;
    end
    check({tag, ".ldac_seen"}, 32'(ldac_n), 32'd0);
    check({tag, ".req_in_ldac"}, 32'(i2c_bus.req), 32'd0);
    low = 0;
    while (!ldac_n && low < 20) begin
      low++;
      tick();
    end
    check({tag, ".ldac_width"}, 32'(low), 32'd4);
  endtask

  initial begin
    int  n;
    bit  seen;
    reset        = 1'b1;
    wr_en        = 1'b0;
    wr_ch        = '0;
    wr_data      = '0;
    commit       = 1'b0;
    err_clr      = 1'b0;
    i2c_bus.ready = 1'b1;
    i2c_bus.done  = 1'b0;
    i2c_bus.nack  = 1'b0;
    repeat (3) tick();
    check_reset_outputs("rst");
    reset = 1'b0;
    tick();

    // Single channel write, latency, commit, LDAC.
    write(4'd3, 12'hABC);
    check("t1.lat_req_low", 32'(i2c_bus.req), 32'd0);
    tick();
    check("t1.lat_req_high", 32'(i2c_bus.req), 32'd1);
    expect_txn("t1", 4'd3, 12'hABC, 1'b0, 1'b1, 1'b0, 12'h000);
    expect_ldac("t1");
    repeat (3) tick();
    check("t1.idle_busy", 32'(busy), 32'd0);

    // Burst of three, held in ISSUE by ready low; round-robin order 2, 9, 15.
    i2c_bus.ready = 1'b0;
    write(4'd2,  12'h222);
    write(4'd9,  12'h999);
    write(4'd15, 12'hFFF);
    repeat (2) tick();
    check("t2.hold_req",  32'(i2c_bus.req),  32'd1);
    check("t2.hold_data", 32'(i2c_bus.data), 32'h2220);
    i2c_bus.ready = 1'b1;
    expect_txn("t2.ch2",  4'd2,  12'h222, 1'b0, 1'b1, 1'b0, 12'h000);
    expect_txn("t2.ch9",  4'd9,  12'h999, 1'b0, 1'b0, 1'b0, 12'h000);
    expect_txn("t2.ch15", 4'd15, 12'hFFF, 1'b0, 1'b0, 1'b0, 12'h000);
    expect_ldac("t2");

    // Three NACKs then ACK: no error.
    write(4'd4, 12'h444);
    expect_txn("t3.n1", 4'd4, 12'h444, 1'b1, 1'b0, 1'b0, 12'h000);
    expect_txn("t3.n2", 4'd4, 12'h444, 1'b1, 1'b0, 1'b0, 12'h000);
    expect_txn("t3.n3", 4'd4, 12'h444, 1'b1, 1'b0, 1'b0, 12'h000);
    expect_txn("t3.ack", 4'd4, 12'h444, 1'b0, 1'b0, 1'b0, 12'h000);
    check("t3.no_error", 32'(error), 32'd0);

    // Four NACKs: error raised, channel dropped.
    write(4'd6, 12'h456);
    expect_txn("t3.e1", 4'd6, 12'h456, 1'b1, 1'b0, 1'b0, 12'h000);
    expect_txn("t3.e2", 4'd6, 12'h456, 1'b1, 1'b0, 1'b0, 12'h000);
    expect_txn("t3.e3", 4'd6, 12'h456, 1'b1, 1'b0, 1'b0, 12'h000);
    expect_txn("t3.e4", 4'd6, 12'h456, 1'b1, 1'b0, 1'b0, 12'h000);
    check("t3.error",  32'(error),  32'd1);
    check("t3.err_ch", 32'(err_ch), 32'd6);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i2c_bus.req) seen = 1'b1;
      tick();
    end
    check("t3.no_resend", 32'(seen), 32'd0);
    check("t3.idle", 32'(busy), 32'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t3.err_clr",    32'(error),  32'd0);
    check("t3.err_ch_clr", 32'(err_ch), 32'd0);

    // Rewrite during WAIT: channel re-sent with new data.
    write(4'd5, 12'h777);
    expect_txn("t4.first", 4'd5, 12'h777, 1'b0, 1'b0, 1'b1, 12'h111);
    expect_txn("t4.resend", 4'd5, 12'h111, 1'b0, 1'b0, 1'b0, 12'h000);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i2c_bus.req) seen = 1'b1;
      tick();
    end
    check("t4.settled", 32'(seen), 32'd0);

    // Two commits during a flush: one pulse after the last ACK.
    write(4'd0, 12'h0A5);
    write(4'd1, 12'h15A);
    expect_txn("t5.ch0", 4'd0, 12'h0A5, 1'b0, 1'b1, 1'b0, 12'h000);
    expect_txn("t5.ch1", 4'd1, 12'h15A, 1'b0, 1'b1, 1'b0, 12'h000);
    expect_ldac("t5");
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!ldac_n) n++;
      tick();
    end
    check("t5.single_pulse", 32'(n), 32'd0);

    // Reset mid-WAIT, then a stray done.
    write(4'd10, 12'hCDE);
    n = 0;
    while (!i2c_bus.req && n < 60) begin
      tick();
      n++;
    end
    check("t6.req_seen", 32'(i2c_bus.req), 32'd1);
    check("t6.addr", 32'(i2c_bus.addr), 32'h2B);
    tick();
    check("t6.in_wait", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check_reset_outputs("t6.rst");
    tick();
    reset = 1'b0;
    tick();
    i2c_bus.done = 1'b1;
    tick();
    i2c_bus.done = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i2c_bus.req || busy || !ldac_n) seen = 1'b1;
      tick();
    end
    check("t6.stray_done", 32'(seen), 32'd0);

    // Recovers normally after reset.
    write(4'd7, 12'h5A5);
    expect_txn("t6.after", 4'd7, 12'h5A5, 1'b0, 1'b0, 1'b0, 12'h000);
    repeat (3) tick();
    check("t6.after_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
